// File: rtl/register_checkpoint_buffer.sv
// rtl/register_checkpoint_buffer.sv - circular buffer of register-file checkpoints with ID-based restore
module register_checkpoint_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int DEPTH      = 4,
  parameter int ID_W       = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_in,
  input  logic                                 take_snapshot,
  output logic [ID_W-1:0]                      snap_id,
  input  logic                                 release_valid,
  input  logic                                 restore_valid,
  input  logic [ID_W-1:0]                      restore_id,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_snapshot,
  output logic                                 done,
  input  logic                                 snapshot_ack,
  output logic                                 restore_err,
  output logic [CNT_W-1:0]                     count,
  output logic                                 full,
  output logic                                 empty
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]  head_q, head_d;
  logic [ID_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] snap_q, snap_d;

  // Checkpoint storage; contents only matter once written by a take.
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q [DEPTH];

  logic            is_idle;
  logic            full_w;
  logic            empty_w;
  logic [ID_W-1:0] restore_off;
  logic            restore_live;
  logic            restore_go;
  logic            restore_rej;
  logic            take_go;
  logic            rel_go;

  assign is_idle = (state_q == ST_IDLE);
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // Distance from the oldest entry, wrapping naturally because DEPTH is a power of two.
  assign restore_off  = restore_id - head_q;
  assign restore_live = (CNT_W'(restore_off) < count_q);

  // A restore request owns the cycle in IDLE; takes and releases alongside it are dropped.
  assign restore_go  = is_idle & restore_valid & restore_live;
  assign restore_rej = is_idle & restore_valid & ~restore_live;
  assign take_go     = is_idle & take_snapshot & ~restore_valid & ~full_w;
  assign rel_go      = release_valid & ~empty_w & ~(is_idle & restore_valid);

  // Pointer, occupancy, snapshot and error next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    snap_d  = snap_q;
    err_d   = restore_rej;
    if (restore_go) begin
      // Discard the restored checkpoint and everything younger than it.
      tail_d  = restore_id;
      count_d = CNT_W'(restore_off);
      snap_d  = mem_q[restore_id];
    end else begin
      if (take_go) begin
        tail_d = tail_q + ID_W'(1);
      end
      if (rel_go) begin
        head_d = head_q + ID_W'(1);
      end
      count_d = count_q + CNT_W'(take_go) - CNT_W'(rel_go);
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      snap_q  <= snap_d;
    end
  end

  // Capture the live register file into the tail entry on an accepted take.
  always_ff @(posedge clk) begin
    if (take_go) begin
      mem_q[tail_q] <= regs_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a live restore waits in DONE until hazard control acknowledges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (restore_go) state_d = ST_DONE;
      ST_DONE: if (snapshot_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    done = 1'b0;
    case (state_q)
      ST_DONE: done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  assign snap_id       = tail_q;
  assign regs_snapshot = snap_q;
  assign restore_err   = err_q;
  assign count         = count_q;
  assign full          = full_w;
  assign empty         = empty_w;

endmodule

// File: tb/tb_register_checkpoint_buffer.sv
// tb/tb_register_checkpoint_buffer.sv - self-checking bench for register_checkpoint_buffer
module tb_register_checkpoint_buffer;

  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;
  localparam int CW    = 3;

  typedef logic [NR-1:0][DW-1:0] image_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  image_t         regs_in = '0;
  logic           take_snapshot = 1'b0;
  logic [IDW-1:0] snap_id;
  logic           release_valid = 1'b0;
  logic           restore_valid = 1'b0;
  logic [IDW-1:0] restore_id = '0;
  image_t         regs_snapshot;
  logic           done;
  logic           snapshot_ack = 1'b0;
  logic           restore_err;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  register_checkpoint_buffer #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .regs_in(regs_in),
    .take_snapshot(take_snapshot), .snap_id(snap_id),
    .release_valid(release_valid), .restore_valid(restore_valid),
    .restore_id(restore_id), .regs_snapshot(regs_snapshot),
    .done(done), .snapshot_ack(snapshot_ack), .restore_err(restore_err),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Register image derived from a seed; register 5 carries the seed itself.
  function automatic image_t img(logic [31:0] s);
    image_t r;
    for (int k = 0; k < NR; k++) begin
      r[k] = s ^ ((32'(k) ^ 32'd5) * 32'h0100_0193);
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_img(string name, image_t act, image_t exp);
    int bad;
    bad = -1;
    for (int k = NR - 1; k >= 0; k--) if (act[k] !== exp[k]) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: reg[%0d] got %0h expected %0h", name, bad, act[bad], exp[bad]);
    end
  endtask

  task automatic idle_inputs();
    take_snapshot = 1'b0;
    release_valid = 1'b0;
    restore_valid = 1'b0;
    restore_id    = '0;
    snapshot_ack  = 1'b0;
  endtask

  // Called just after a rising edge; reset pulse completes before the next edge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit             pre_reset;
    bit             take, rel, rv;
    logic [IDW-1:0] rid;
    bit             ack;
    logic [31:0]    seed;
    logic [IDW-1:0] sid_pre;
    int             cnt;
    bit             fl, em, dn, er, c5;
    logic [31:0]    r5;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit pr, bit tk, bit rl, bit rv, int rid, bit ak, logic [31:0] seed,
                              int sid, int cnt, bit fl, bit em, bit dn, bit er, bit c5, logic [31:0] r5);
    vec_t v;
    v.pre_reset = pr; v.take = tk; v.rel = rl; v.rv = rv; v.rid = IDW'(rid); v.ack = ak;
    v.seed = seed; v.sid_pre = IDW'(sid); v.cnt = cnt; v.fl = fl; v.em = em; v.dn = dn;
    v.er = er; v.c5 = c5; v.r5 = r5;
    return v;
  endfunction

  // Reference model: the live checkpoints as an ordered queue, oldest first.
  typedef struct {
    int          id;
    logic [31:0] seed;
  } ent_t;

  ent_t   m_q[$];
  int     m_tail;
  bit     m_done;
  bit     m_err;
  image_t m_snap;

  task automatic model_reset();
    m_q.delete();
    m_tail = 0;
    m_done = 0;
    m_err  = 0;
    m_snap = '0;
  endtask

  task automatic model_step(bit tk, bit rl, bit rv, int rid, bit ak, logic [31:0] seed);
    int   sz;
    int   found;
    ent_t e;
    m_err = 0;
    sz = m_q.size();
    if (!m_done) begin
      if (rv) begin
        found = -1;
        for (int i = 0; i < sz; i++) if (m_q[i].id == rid) found = i;
        if (found >= 0) begin
          m_snap = img(m_q[found].seed);
          while (m_q.size() > found) void'(m_q.pop_back());
          m_tail = rid;
          m_done = 1;
        end else begin
          m_err = 1;
        end
      end else begin
        if (tk && sz < DEPTH) begin
          e.id = m_tail;
          e.seed = seed;
          m_q.push_back(e);
          m_tail = (m_tail + 1) % DEPTH;
        end
        if (rl && sz > 0) void'(m_q.pop_front());
      end
    end else begin
      if (rl && sz > 0) void'(m_q.pop_front());
      if (ak) m_done = 0;
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] seed;
    bit          tk, rl, rv, ak;
    int          rid;

    // Reset state while rst_n is held low.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset count", count, 0);
    check("reset empty", empty, 1);
    check("reset full", full, 0);
    check("reset snap_id", snap_id, 0);
    check("reset done", done, 0);
    check("reset restore_err", restore_err, 0);
    check_img("reset regs_snapshot", regs_snapshot, '0);
    rst_n = 1'b1;

    // Fill, overflow drop, restore with delayed ack.
    vecs.push_back(mk(0,1,0,0,0,0,32'h11, 0,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'h22, 1,2,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'h33, 2,3,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'h44, 3,4,1,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'h55, 0,4,1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,32'h0,  0,1,0,0,1,0,1,32'h22));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,  1,1,0,0,1,0,1,32'h22));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,  1,1,0,0,1,0,1,32'h22));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,  1,1,0,0,1,0,1,32'h22));
    vecs.push_back(mk(0,0,0,0,0,1,32'h0,  1,1,0,0,0,0,1,32'h22));
    // Wrap-around.
    vecs.push_back(mk(1,1,0,0,0,0,32'hA1, 0,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'hA2, 1,2,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'hA3, 2,3,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,32'h0,  3,2,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,32'h0,  3,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,32'h0,  3,0,0,1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'hB1, 3,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'hB2, 0,2,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'hB3, 1,3,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,32'h0,  2,1,0,0,1,0,1,32'hB2));
    vecs.push_back(mk(0,0,0,0,0,1,32'h0,  0,1,0,0,0,0,1,32'hB2));
    // Rejected restore, take+release, restore+take.
    vecs.push_back(mk(1,1,0,0,0,0,32'hC1, 0,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'hC2, 1,2,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,2,0,32'h0,  2,2,0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,  2,2,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,32'hC3, 2,2,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,  3,2,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,32'h0,  3,2,0,0,0,1,0,0));
    vecs.push_back(mk(0,1,0,1,2,0,32'hD1, 3,1,0,0,1,0,1,32'hC3));
    vecs.push_back(mk(0,0,0,0,0,1,32'h0,  2,1,0,0,0,0,1,32'hC3));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,  2,1,0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.pre_reset) do_reset();
      take_snapshot = v.take;
      release_valid = v.rel;
      restore_valid = v.rv;
      restore_id    = v.rid;
      snapshot_ack  = v.ack;
      regs_in       = img(v.seed);
      check($sformatf("v%0d snap_id", i), snap_id, v.sid_pre);
      @(posedge clk);
      #1;
      check($sformatf("v%0d count", i), count, v.cnt);
      check($sformatf("v%0d full", i), full, v.fl);
      check($sformatf("v%0d empty", i), empty, v.em);
      check($sformatf("v%0d done", i), done, v.dn);
      check($sformatf("v%0d restore_err", i), restore_err, v.er);
      if (v.c5) check($sformatf("v%0d regs_snapshot[5]", i), regs_snapshot[5], v.r5);
    end

    // Reset asserted while a restore is awaiting ack.
    idle_inputs();
    take_snapshot = 1'b1;
    regs_in = img(32'hE1);
    @(posedge clk);
    #1;
    take_snapshot = 1'b0;
    restore_valid = 1'b1;
    restore_id = 2'd1;
    @(posedge clk);
    #1;
    restore_valid = 1'b0;
    check("pre-reset done", done, 1);
    check("pre-reset regs_snapshot[5]", regs_snapshot[5], 32'hC2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset done", done, 0);
    check("async reset count", count, 0);
    check("async reset empty", empty, 1);
    #1;
    rst_n = 1'b1;
    #1;
    take_snapshot = 1'b1;
    regs_in = img(32'hF1);
    check("post-reset snap_id", snap_id, 0);
    @(posedge clk);
    #1;
    take_snapshot = 1'b0;
    check("post-reset count", count, 1);

    // Randomized traffic against the queue model.
    do_reset();
    model_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 800; c++) begin
      check("rnd count", count, m_q.size());
      check("rnd full", full, m_q.size() == DEPTH);
      check("rnd empty", empty, m_q.size() == 0);
      check("rnd snap_id", snap_id, m_tail);
      check("rnd done", done, m_done);
      check("rnd restore_err", restore_err, m_err);
      check_img("rnd regs_snapshot", regs_snapshot, m_snap);
      tk   = ($urandom_range(0, 99) < 50);
      rl   = ($urandom_range(0, 99) < 30);
      rv   = ($urandom_range(0, 99) < 15);
      ak   = ($urandom_range(0, 99) < 40);
      rid  = $urandom_range(0, DEPTH - 1);
      seed = $urandom;
      take_snapshot = tk;
      release_valid = rl;
      restore_valid = rv;
      restore_id    = IDW'(rid);
      snapshot_ack  = ak;
      regs_in       = img(seed);
      model_step(tk, rl, rv, rid, ak, seed);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_checkpoint_buffer.md
# register_checkpoint_buffer

Multi-entry successor to the single-slot register snapshot: holds up to DEPTH architectural register-file checkpoints, one per unresolved predicted branch, in a circular buffer. Hazard control takes a checkpoint when a prediction path starts, releases the oldest when a branch resolves correctly, and requests a restore by checkpoint ID on a mispredict. A restore returns the selected register image with a done/ack handshake and discards that checkpoint and every younger one. Sits between hazard control and the register file.

## Interface
- DATA_WIDTH, 32, register width
- NUM_REGS, 32, registers per checkpoint
- DEPTH, 4, checkpoint entries; power of two, ≥2
- ID_W, $clog2(DEPTH), checkpoint ID width (derived)
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- regs_in  in  DATA_WIDTH x NUM_REGS  live register-file contents
- take_snapshot  in  1  capture regs_in into a new entry this cycle
- snap_id  out  ID_W  ID the entry captured on a take this cycle receives (= tail pointer)
- release_valid  in  1  free oldest live entry (branch resolved correct)
- restore_valid  in  1  restore request (mispredict)
- restore_id  in  ID_W  entry to restore
- regs_snapshot  out  DATA_WIDTH x NUM_REGS  restored register image
- done  out  1  restore data valid; held until acknowledged
- snapshot_ack  in  1  hazard control has consumed regs_snapshot
- restore_err  out  1  one-cycle pulse: restore_id not live, request dropped
- count  out  $clog2(DEPTH+1)  live entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH x NUM_REGS x DATA_WIDTH array; head = oldest live, tail = next free; both wrap mod DEPTH. Storage array is not reset.
- FSM: IDLE, DONE.
- IDLE, take_snapshot && !full && !restore_valid: entry[tail] <= regs_in, tail++, count++.
- IDLE, release_valid && !empty && !restore_valid: head++, count--.
- Take and release in the same cycle: both applied, count unchanged. Take while full is dropped even with a simultaneous release.
- IDLE, restore_valid: live iff ((restore_id - head) mod DEPTH) < count. If live: regs_snapshot <= entry[restore_id], tail <= restore_id, count <= (restore_id - head) mod DEPTH, go DONE. If not live: restore_err pulses, no state change, stay IDLE.
- restore_valid has priority; a concurrent take or release is dropped.
- DONE: done = 1. Take and restore are ignored; release is honoured with the IDLE rules. On snapshot_ack, go IDLE.
- snapshot_ack in IDLE has no effect.
- regs_snapshot holds its value until the next successful restore.

## Timing
- Reset (async assert): head = tail = 0, count = 0, empty = 1, full = 0, snap_id = 0, done = 0, restore_err = 0, regs_snapshot all 0, FSM in IDLE.
- count, full, empty and snap_id are registered-state derived; they update the cycle after the edge that changes the state.
- snap_id is valid in the same cycle take_snapshot is asserted.
- Restore latency:
  - Request sampled at edge N.
  - regs_snapshot valid and done = 1 from edge N through the edge where snapshot_ack is sampled high.
  - done = 0 after that edge.
  - Earliest next restore is sampled on the following edge.
- restore_err is high for exactly the cycle after the rejected request.
- Reset asserted mid-restore clears done immediately; the pending handshake is abandoned.

## Test plan
- Reset, then 4 takes with regs_in[5] = 0x11, 0x22, 0x33, 0x44 -> snap_id 0, 1, 2, 3; then count = 4, full = 1; a 5th take is dropped with count = 4.
- Restore ID 1 with head = 0 and 4 live -> next cycle regs_snapshot[5] = 0x22, done = 1, count = 1, tail = 1. done stays 1 for 3 cycles without ack and clears the cycle after ack.
- Wrap-around: 3 takes, 3 releases, 3 takes -> IDs 3, 0, 1. Restore ID 0 -> returns the 2nd post-wrap image, count = 1.
- Restore of ID 2 when only IDs 0–1 are live -> restore_err pulse, count unchanged, done = 0.
- Same-cycle take + release at count = 2 -> count stays 2, head and tail both advance. Same-cycle restore + take -> take dropped, restore performed.
- rst_n low during DONE -> done = 0 and count = 0 immediately. A take after reset returns snap_id 0.
